// File: rtl/dff.sv
// Parameterised D flip-flop pipeline: a chain of STAGES registers, each WIDTH
// bits wide, with asynchronous active-low reset to RESET_VALUE.
//
// Ports:
//   clk - clock; all stage updates on the rising edge
//   rst - asynchronous reset, active-low (0 = reset asserted)
//   d   - data input, sampled at the rising clk edge
//   q   - output of the last register stage (STAGES cycles of latency)
//   qn  - bitwise complement of q
module dff #(
  parameter int unsigned          WIDTH       = 1,
  parameter int unsigned          STAGES      = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] pipe [STAGES];

  // Shift chain: stage 0 takes d, every later stage takes its predecessor.
  // Reset wins over a coincident clock edge and flushes in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        pipe[i] <= RESET_VALUE;
      end
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // q comes straight from the last register; qn is its inverse, so neither
  // has a combinational path from d.
  assign q  = pipe[STAGES-1];
  assign qn = ~q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: a single-bit, single-stage instance and an
// 8-bit, three-stage instance with reset value 8'hA5, sharing one clock.
module tb_dff;

  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;
  localparam logic [7:0]  RV3 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst1;
  logic       d1;
  logic       q1;
  logic       qn1;
  logic       rst3;
  logic [7:0] d3;
  logic [7:0] q3;
  logic [7:0] qn3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff #(.WIDTH(1), .STAGES(S1), .RESET_VALUE(1'b0)) u_dff1 (
    .clk (clk),
    .rst (rst1),
    .d   (d1),
    .q   (q1),
    .qn  (qn1)
  );

  dff #(.WIDTH(8), .STAGES(S3), .RESET_VALUE(RV3)) u_dff3 (
    .clk (clk),
    .rst (rst3),
    .d   (d3),
    .q   (q3),
    .qn  (qn3)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the history of samples taken since the last reset. q is the
  // sample from STAGES edges ago, or the reset value if fewer have been taken.
  bit         m1_ok = 1'b0;
  bit         m3_ok = 1'b0;
  logic       h1[$];
  logic [7:0] h3[$];

  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      h1.delete();
      m1_ok = 1'b1;
    end else begin
      h1.push_back(d1);
    end
  end

  always @(posedge clk or negedge rst3) begin
    if (!rst3) begin
      h3.delete();
      m3_ok = 1'b1;
    end else begin
      h3.push_back(d3);
    end
  end

  function automatic logic exp1();
    if (h1.size() >= S1) return h1[h1.size() - S1];
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp3();
    if (h3.size() >= S3) return h3[h3.size() - S3];
    return RV3;
  endfunction

  // Every-cycle comparison against the model, once power-up state is gone.
  always @(negedge clk) begin
    if (m1_ok) begin
      chk("m1_q",  {7'b0, q1},  {7'b0, exp1()});
      chk("m1_qn", {7'b0, qn1}, {7'b0, 1'(~exp1())});
    end
    if (m3_ok) begin
      chk("m3_q",  q3,  exp3());
      chk("m3_qn", qn3, ~exp3());
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst1 = 1'b0;
    d1   = 1'b1;
    rst3 = 1'b0;
    d3   = 8'h00;

    // Reset held with d=1 and clock running
    repeat (3) tick();
    chk("rst_q1",  {7'b0, q1},  8'h00);
    chk("rst_qn1", {7'b0, qn1}, 8'h01);

    // Basic capture, d changes mid-cycle
    rst1 = 1'b1;
    d1   = 1'b0;
    tick();
    chk("cap_q0", {7'b0, q1}, 8'h00);
    #1 d1 = 1'b1;
    #1 chk("cap_mid_hold0", {7'b0, q1}, 8'h00);
    tick();
    chk("cap_rise", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #2 chk("cap_mid_hold1", {7'b0, q1}, 8'h01);
    tick();
    chk("cap_fall", {7'b0, q1}, 8'h00);

    // Asynchronous reset between edges
    d1 = 1'b1;
    tick();
    chk("ar_pre", {7'b0, q1}, 8'h01);
    rst1 = 1'b0;
    #1;
    chk("ar_q_now",  {7'b0, q1},  8'h00);
    chk("ar_qn_now", {7'b0, qn1}, 8'h01);
    repeat (2) tick();
    chk("ar_hold", {7'b0, q1}, 8'h00);

    // Release with d=1
    rst1 = 1'b1;
    #1 chk("rel_before_edge", {7'b0, q1}, 8'h00);
    tick();
    chk("rel_first_edge", {7'b0, q1}, 8'h01);

    // Three-stage latency
    rst3 = 1'b1;
    d3   = 8'h01;
    tick(); chk("lat_e1", q3, 8'hA5);
    d3 = 8'h02;
    tick(); chk("lat_e2", q3, 8'hA5);
    d3 = 8'h03;
    tick(); chk("lat_e3", q3, 8'h01);
    d3 = 8'h04;
    tick(); chk("lat_e4", q3, 8'h02);
    tick(); chk("lat_e5", q3, 8'h03);
    chk("lat_qn", qn3, 8'hFC);

    // Refill, then reset with 8'h02 and 8'h03 in flight
    rst3 = 1'b0;
    #1 chk("mp_rst_a", q3, 8'hA5);
    tick();
    rst3 = 1'b1;
    d3   = 8'h01;
    tick(); d3 = 8'h02;
    tick(); d3 = 8'h03;
    tick(); chk("mp_fill", q3, 8'h01);
    rst3 = 1'b0;
    #1;
    chk("mp_rst_q",  q3,  8'hA5);
    chk("mp_rst_qn", qn3, 8'h5A);
    tick(); chk("mp_hold", q3, 8'hA5);

    // After release, only the new data emerges
    rst3 = 1'b1;
    d3   = 8'h10;
    tick(); chk("mp_e1", q3, 8'hA5);
    d3 = 8'h11;
    tick(); chk("mp_e2", q3, 8'hA5);
    d3 = 8'h12;
    tick(); chk("mp_e3", q3, 8'h10);
    d3 = 8'h13;
    tick(); chk("mp_e4", q3, 8'h11);
    tick(); chk("mp_e5", q3, 8'h12);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits; SHALL accept any integer >= 1.
REQ-002 Parameter STAGES, default 1: number of cascaded register stages (latency in clock cycles); SHALL accept any integer >= 1.
REQ-003 Parameter RESET_VALUE, default all-zeros (WIDTH bits): value loaded into every stage on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge only.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 d  input  WIDTH  data input, sampled at the rising clk edge.
REQ-007 q  output  WIDTH  registered data output, driven by the last stage.
REQ-008 qn  output  WIDTH  bitwise complement of q; may be left unconnected.

Function
REQ-009 The block SHALL implement a chain of STAGES registers, each WIDTH bits wide; stage 0 loads d, and stage k loads stage k-1.
REQ-010 With rst=1, on each rising clk edge all stages SHALL shift by one position simultaneously.
REQ-011 q SHALL equal the value of d sampled STAGES rising edges earlier, provided rst stayed high throughout; for STAGES=1, q updates to d at each rising edge.
REQ-012 q SHALL change only on a rising clk edge or on rst assertion; d changes between edges SHALL have no effect on q.
REQ-013 qn SHALL always equal ~q combinationally, including during reset (~RESET_VALUE).
REQ-014 The block SHALL contain no combinational path from d to q or qn.
REQ-015 The block SHALL have no enable; every rising edge with rst=1 loads.
REQ-016 Outputs SHALL be registered values only; there are no X-propagation special cases beyond normal register semantics.

Reset
REQ-017 When rst falls to 0, all stages SHALL take RESET_VALUE immediately, without waiting for a clk edge.
REQ-018 While rst=0, all stages SHALL hold RESET_VALUE regardless of clk and d activity.
REQ-019 Reset SHALL take priority over a coincident rising clk edge.
REQ-020 Deassertion: if rst rises at or before a rising clk edge, that edge SHALL sample d normally. Deassertion timing relative to clk is the integrator's responsibility; no internal synchronizer.
REQ-021 If reset is asserted mid-pipeline, in-flight data SHALL be discarded. After release, q SHALL show RESET_VALUE until STAGES edges have elapsed, then the post-release d values.
REQ-022 Power-up state before the first reset is undefined. Verification SHALL apply reset before checking q.

Verification
REQ-023 Reset at start: WIDTH=1, STAGES=1; rst=0 at t=0, d=1, clk toggling -> q=0 and qn=1 throughout reset.
REQ-024 Basic capture: rst=1, d goes 0->1 mid-cycle -> q stays 0 until the next rising edge, then becomes 1. d returning to 0 mid-cycle -> q=0 only after the following edge.
REQ-025 Asynchronous reset: q=1, drive rst=0 between clock edges -> q=0 at once, before any clk edge. Hold rst=0 for 2 cycles with d=1 -> q stays 0.
REQ-026 Release: rst 0->1 with d=1 -> q=1 at the first rising edge after release.
REQ-027 Latency: WIDTH=8, STAGES=3, RESET_VALUE=8'hA5; after reset, apply d=8'h01, 8'h02, 8'h03 on consecutive edges -> q=8'hA5 for the first two edges, then 8'h01, 8'h02, 8'h03.
REQ-028 Mid-pipeline reset: same configuration, assert rst=0 with 8'h02 and 8'h03 in flight -> q=8'hA5 immediately. After release, q=8'hA5 until 3 edges with new data have elapsed; 8'h02 and 8'h03 never appear.
